// File: rtl/wb_regfile.sv
// wb_regfile: writeback stage with a one-entry result buffer, the
// architectural register file, and a per-register pending-write scoreboard
// that lets ID stall on RAW hazards and throttle issue at three in flight.
module wb_regfile #(
  parameter int XLEN           = 64,
  parameter int REG_DATA_DEPTH = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      issue_valid,
  input  logic                      issue_wen,
  input  logic [REG_ADDR_WIDTH-1:0] issue_waddr,
  output logic                      issue_ready,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
  output logic                      write_ready,
  input  logic                      mem_valid,
  output logic                      mem_ready,
  input  logic                      mem_reg_wen,
  input  logic [REG_ADDR_WIDTH-1:0] mem_reg_waddr,
  input  logic [XLEN-1:0]           mem_alu_res,
  input  logic [XLEN-1:0]           mem_rdata,
  input  logic                      mem_load,
  input  logic [1:0]                mem_ld_size,
  input  logic                      mem_ld_signed,
  input  logic                      wb_stall,
  output logic                      wb_reg_wen,
  output logic [REG_ADDR_WIDTH-1:0] wb_reg_waddr,
  output logic [XLEN-1:0]           wb_data,
  output logic                      wb_commit,
  output logic                      sb_err,
  output logic [XLEN-1:0]           reg_f [REG_DATA_DEPTH]
);

  logic                      wb_valid_q, wb_valid_d;
  logic                      wb_wen_q, wb_wen_d;
  logic [REG_ADDR_WIDTH-1:0] wb_waddr_q, wb_waddr_d;
  logic [XLEN-1:0]           wb_data_q, wb_data_d;
  logic [XLEN-1:0]           reg_f_q [REG_DATA_DEPTH];
  logic [XLEN-1:0]           reg_f_d [REG_DATA_DEPTH];
  logic [1:0]                cnt_q [REG_DATA_DEPTH];
  logic [1:0]                cnt_d [REG_DATA_DEPTH];
  logic                      sb_err_q, sb_err_d;

  logic                      commit;
  logic                      accept;
  logic                      issue_fire;
  logic                      inc_en;
  logic                      dec_en;
  logic [XLEN-1:0]           ld_data;

  // Handshakes: a draining entry frees the slot for a same-cycle accept;
  // hazard and issue checks look only at registered counts.
  always_comb begin
    commit      = wb_valid_q && !wb_stall;
    mem_ready   = !wb_valid_q || commit;
    accept      = mem_valid && mem_ready;
    issue_ready = !(issue_wen && (issue_waddr != '0) && (cnt_q[issue_waddr] == 2'd3));
    issue_fire  = issue_valid && issue_ready;
    inc_en      = issue_fire && issue_wen && (issue_waddr != '0);
    dec_en      = commit && wb_wen_q && (wb_waddr_q != '0);
    write_ready = ((id_rs1 == '0) || (cnt_q[id_rs1] == 2'd0)) &&
                  ((id_rs2 == '0) || (cnt_q[id_rs2] == 2'd0));
  end

  // Result select; load data arrives right-aligned so only extension is needed.
  always_comb begin
    ld_data = mem_alu_res;
    if (mem_load) begin
      case (mem_ld_size)
        2'd0:    ld_data = {{(XLEN-8){mem_ld_signed & mem_rdata[7]}}, mem_rdata[7:0]};
        2'd1:    ld_data = {{(XLEN-16){mem_ld_signed & mem_rdata[15]}}, mem_rdata[15:0]};
        2'd2:    ld_data = {{(XLEN-32){mem_ld_signed & mem_rdata[31]}}, mem_rdata[31:0]};
        default: ld_data = mem_rdata;
      endcase
    end
  end

  // Next state for the WB entry, register file and scoreboard.
  always_comb begin
    wb_valid_d = wb_valid_q;
    wb_wen_d   = wb_wen_q;
    wb_waddr_d = wb_waddr_q;
    wb_data_d  = wb_data_q;
    reg_f_d    = reg_f_q;
    cnt_d      = cnt_q;
    sb_err_d   = sb_err_q;

    if (accept) begin
      wb_valid_d = 1'b1;
      wb_wen_d   = mem_reg_wen;
      wb_waddr_d = mem_reg_waddr;
      wb_data_d  = ld_data;
    end else if (commit) begin
      wb_valid_d = 1'b0;
      wb_wen_d   = 1'b0;
    end

    if (dec_en) begin
      reg_f_d[wb_waddr_q] = wb_data_q;
    end

    // A same-register increment and decrement cancel, so no underflow check.
    if (!(inc_en && dec_en && (issue_waddr == wb_waddr_q))) begin
      if (inc_en) begin
        cnt_d[issue_waddr] = cnt_q[issue_waddr] + 2'd1;
      end
      if (dec_en) begin
        if (cnt_q[wb_waddr_q] == 2'd0) begin
          sb_err_d = 1'b1;
        end else begin
          cnt_d[wb_waddr_q] = cnt_q[wb_waddr_q] - 2'd1;
        end
      end
    end

    reg_f_d[0] = '0;
    cnt_d[0]   = '0;
  end

  // State update; reset wins over everything and drops a stalled entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_valid_q <= 1'b0;
      wb_wen_q   <= 1'b0;
      wb_waddr_q <= '0;
      wb_data_q  <= '0;
      sb_err_q   <= 1'b0;
      for (int i = 0; i < REG_DATA_DEPTH; i++) begin
        reg_f_q[i] <= '0;
        cnt_q[i]   <= '0;
      end
    end else begin
      wb_valid_q <= wb_valid_d;
      wb_wen_q   <= wb_wen_d;
      wb_waddr_q <= wb_waddr_d;
      wb_data_q  <= wb_data_d;
      sb_err_q   <= sb_err_d;
      reg_f_q    <= reg_f_d;
      cnt_q      <= cnt_d;
    end
  end

  assign wb_reg_wen   = wb_wen_q;
  assign wb_reg_waddr = wb_waddr_q;
  assign wb_data      = wb_data_q;
  assign wb_commit    = commit;
  assign sb_err       = sb_err_q;
  assign reg_f        = reg_f_q;

endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed scenarios followed by a randomized phase, all
// checked against a behavioural model of the writeback stage.
module tb_wb_regfile;

  logic        clk;
  logic        rst_n;
  logic        issue_valid;
  logic        issue_wen;
  logic [4:0]  issue_waddr;
  logic        issue_ready;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        write_ready;
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_reg_wen;
  logic [4:0]  mem_reg_waddr;
  logic [63:0] mem_alu_res;
  logic [63:0] mem_rdata;
  logic        mem_load;
  logic [1:0]  mem_ld_size;
  logic        mem_ld_signed;
  logic        wb_stall;
  logic        wb_reg_wen;
  logic [4:0]  wb_reg_waddr;
  logic [63:0] wb_data;
  logic        wb_commit;
  logic        sb_err;
  logic [63:0] reg_f [32];

  int vectors     = 0;
  int miscompares = 0;

  // Model: architectural registers, outstanding-write counts, a sticky
  // underflow flag and at most one held result.
  logic [63:0] m_reg [32];
  int          m_cnt [32];
  logic        m_err;
  logic        m_full;
  logic        m_wen;
  logic [4:0]  m_waddr;
  logic [63:0] m_data;

  wb_regfile #(.XLEN(64), .REG_DATA_DEPTH(32), .REG_ADDR_WIDTH(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_wen(issue_wen), .issue_waddr(issue_waddr),
    .issue_ready(issue_ready),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .write_ready(write_ready),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_reg_wen(mem_reg_wen),
    .mem_reg_waddr(mem_reg_waddr), .mem_alu_res(mem_alu_res), .mem_rdata(mem_rdata),
    .mem_load(mem_load), .mem_ld_size(mem_ld_size), .mem_ld_signed(mem_ld_signed),
    .wb_stall(wb_stall),
    .wb_reg_wen(wb_reg_wen), .wb_reg_waddr(wb_reg_waddr), .wb_data(wb_data),
    .wb_commit(wb_commit), .sb_err(sb_err),
    .reg_f(reg_f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_reg[i] = '0;
      m_cnt[i] = 0;
    end
    m_err   = 1'b0;
    m_full  = 1'b0;
    m_wen   = 1'b0;
    m_waddr = '0;
    m_data  = '0;
  endtask

  function automatic logic [63:0] ld_value();
    logic [63:0] mask;
    logic [63:0] v;
    int          nbits;
    if (!mem_load) return mem_alu_res;
    nbits = 8 << mem_ld_size;
    if (nbits == 64) return mem_rdata;
    mask = (64'd1 << nbits) - 64'd1;
    v = mem_rdata & mask;
    if (mem_ld_signed && mem_rdata[nbits-1]) v = v | ~mask;
    return v;
  endfunction

  // One clock: check combinational outputs, advance model and DUT, check state.
  task automatic step();
    logic pc, pf, pa, rdy, wr;
    logic [63:0] nd;
    #1;
    pc  = m_full && !wb_stall;
    rdy = !(issue_wen && issue_waddr != 0 && m_cnt[issue_waddr] == 3);
    pf  = issue_valid && rdy;
    pa  = mem_valid && (!m_full || pc);
    wr  = (id_rs1 == 0 || m_cnt[id_rs1] == 0) && (id_rs2 == 0 || m_cnt[id_rs2] == 0);
    nd  = ld_value();
    chk1("mem_ready", mem_ready, !m_full || pc);
    chk1("wb_commit", wb_commit, pc);
    chk1("issue_ready", issue_ready, rdy);
    chk1("write_ready", write_ready, wr);
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      if (pf && issue_wen && issue_waddr != 0) m_cnt[issue_waddr] += 1;
      if (pc && m_wen && m_waddr != 0) begin
        m_reg[m_waddr] = m_data;
        m_cnt[m_waddr] -= 1;
        if (m_cnt[m_waddr] < 0) begin
          m_cnt[m_waddr] = 0;
          m_err = 1'b1;
        end
      end
      if (pa) begin
        m_full  = 1'b1;
        m_wen   = mem_reg_wen;
        m_waddr = mem_reg_waddr;
        m_data  = nd;
      end else if (pc) begin
        m_full = 1'b0;
      end
    end
    #1;
    chk1("wb_reg_wen", wb_reg_wen, m_full && m_wen);
    if (m_full) begin
      chk64("wb_reg_waddr", 64'(wb_reg_waddr), 64'(m_waddr));
      chk64("wb_data", wb_data, m_data);
    end
    chk1("sb_err", sb_err, m_err);
    for (int i = 0; i < 32; i++) chk64($sformatf("reg_f[%0d]", i), reg_f[i], m_reg[i]);
  endtask

  logic [63:0] ld_rdata [5] = '{64'h1234_5678_9ABC_DE80, 64'h1234_5678_9ABC_DE80,
                                64'h5555_5555_8000_0000, 64'h0000_0000_0000_8001,
                                64'h8000_0000_0000_0001};
  logic [1:0]  ld_size  [5] = '{2'd0, 2'd0, 2'd2, 2'd1, 2'd3};
  logic        ld_sgn   [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
  logic [63:0] ld_exp   [5] = '{64'hFFFF_FFFF_FFFF_FF80, 64'h0000_0000_0000_0080,
                                64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_FFFF_8001,
                                64'h8000_0000_0000_0001};

  initial begin
    rst_n = 1'b0; issue_valid = 1'b0; issue_wen = 1'b0; issue_waddr = '0;
    id_rs1 = '0; id_rs2 = '0; mem_valid = 1'b0; mem_reg_wen = 1'b0;
    mem_reg_waddr = '0; mem_alu_res = '0; mem_rdata = '0; mem_load = 1'b0;
    mem_ld_size = '0; mem_ld_signed = 1'b0; wb_stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    chk1("rst mem_ready", mem_ready, 1'b1);
    chk1("rst issue_ready", issue_ready, 1'b1);
    chk1("rst write_ready", write_ready, 1'b1);
    chk1("rst wb_commit", wb_commit, 1'b0);
    chk1("rst wb_reg_wen", wb_reg_wen, 1'b0);
    chk64("rst wb_data", wb_data, 64'd0);
    chk1("rst sb_err", sb_err, 1'b0);
    step();
    rst_n = 1'b1;
    step();

    // RAW hazard on x5 clears the cycle after its commit.
    issue_valid = 1'b1; issue_wen = 1'b1; issue_waddr = 5'd5;
    step();
    issue_valid = 1'b0; id_rs1 = 5'd5;
    #1 chk1("x5 pending write_ready", write_ready, 1'b0);
    mem_valid = 1'b1; mem_reg_wen = 1'b1; mem_reg_waddr = 5'd5; mem_alu_res = 64'h1234;
    step();
    mem_valid = 1'b0;
    #1 chk1("x5 commit pulse", wb_commit, 1'b1);
    chk1("x5 commit write_ready", write_ready, 1'b0);
    step();
    chk64("x5 value", reg_f[5], 64'h1234);
    #1 chk1("x5 released write_ready", write_ready, 1'b1);
    id_rs1 = '0;

    // Load extension.
    mem_load = 1'b1; mem_reg_waddr = 5'd10; issue_waddr = 5'd10;
    for (int k = 0; k < 5; k++) begin
      issue_valid = 1'b1; mem_valid = 1'b1;
      mem_rdata = ld_rdata[k]; mem_ld_size = ld_size[k]; mem_ld_signed = ld_sgn[k];
      step();
      chk64($sformatf("load %0d wb_data", k), wb_data, ld_exp[k]);
      issue_valid = 1'b0; mem_valid = 1'b0;
      step();
      chk64($sformatf("load %0d reg", k), reg_f[10], ld_exp[k]);
    end
    mem_load = 1'b0; mem_ld_signed = 1'b0; mem_ld_size = '0;

    // Scoreboard saturation on x7.
    issue_valid = 1'b1; issue_waddr = 5'd7;
    repeat (3) step();
    issue_valid = 1'b0;
    #1 chk1("x7 full issue_ready", issue_ready, 1'b0);
    issue_waddr = 5'd8;
    #1 chk1("x8 issue_ready", issue_ready, 1'b1);
    issue_waddr = 5'd7;
    mem_valid = 1'b1; mem_reg_waddr = 5'd7; mem_alu_res = 64'h77;
    step();
    mem_valid = 1'b0;
    step();
    #1 chk1("x7 after commit issue_ready", issue_ready, 1'b1);
    mem_valid = 1'b1;
    step();
    mem_valid = 1'b0; issue_valid = 1'b1;
    #1 chk1("x7 same-edge commit", wb_commit, 1'b1);
    step();
    issue_valid = 1'b0;
    #1 chk1("x7 count 2 issue_ready", issue_ready, 1'b1);
    issue_valid = 1'b1;
    step();
    issue_valid = 1'b0;
    #1 chk1("x7 count 3 issue_ready", issue_ready, 1'b0);
    mem_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1 chk1("back-to-back mem_ready", mem_ready, 1'b1);
      step();
    end
    mem_valid = 1'b0;
    step();
    id_rs1 = 5'd7;
    #1 chk1("x7 drained write_ready", write_ready, 1'b1);
    id_rs1 = '0;

    // Stall holds the entry and blocks the next accept.
    issue_valid = 1'b1; issue_waddr = 5'd12;
    mem_valid = 1'b1; mem_reg_waddr = 5'd12; mem_alu_res = 64'h5A5A;
    step();
    issue_waddr = 5'd13; wb_stall = 1'b1;
    mem_reg_waddr = 5'd13; mem_alu_res = 64'h0077;
    #1 chk1("stall mem_ready", mem_ready, 1'b0);
    step();
    issue_valid = 1'b0;
    step();
    chk64("stall reg unchanged", reg_f[12], 64'd0);
    chk64("stall wb_data held", wb_data, 64'h5A5A);
    wb_stall = 1'b0;
    #1 chk1("release commit", wb_commit, 1'b1);
    chk1("release mem_ready", mem_ready, 1'b1);
    step();
    chk64("release x12", reg_f[12], 64'h5A5A);
    chk64("next entry waddr", 64'(wb_reg_waddr), 64'd13);
    mem_valid = 1'b0;
    step();
    chk64("x13 value", reg_f[13], 64'h0077);

    // Writes to x0 are dropped; an unmatched commit flags underflow.
    issue_valid = 1'b1; issue_waddr = 5'd0;
    mem_valid = 1'b1; mem_reg_waddr = 5'd0; mem_alu_res = 64'hDEAD;
    step();
    issue_valid = 1'b0; mem_valid = 1'b0;
    step();
    chk64("x0 stays zero", reg_f[0], 64'd0);
    chk1("x0 no sb_err", sb_err, 1'b0);
    mem_valid = 1'b1; mem_reg_waddr = 5'd9; mem_alu_res = 64'h99;
    step();
    mem_valid = 1'b0;
    step();
    chk1("x9 underflow sb_err", sb_err, 1'b1);
    step();
    chk1("sb_err sticky", sb_err, 1'b1);

    // Reset during a stalled entry with counts outstanding.
    issue_valid = 1'b1; issue_waddr = 5'd3;
    step();
    mem_valid = 1'b1; mem_reg_waddr = 5'd3; mem_alu_res = 64'hBEEF;
    step();
    issue_valid = 1'b0; mem_valid = 1'b0; wb_stall = 1'b1;
    step();
    rst_n = 1'b0;
    step();
    chk1("rst stall wb_reg_wen", wb_reg_wen, 1'b0);
    chk64("rst stall waddr", 64'(wb_reg_waddr), 64'd0);
    chk64("rst stall wb_data", wb_data, 64'd0);
    chk1("rst stall sb_err", sb_err, 1'b0);
    chk64("rst stall x3", reg_f[3], 64'd0);
    rst_n = 1'b1; wb_stall = 1'b0; id_rs1 = 5'd3; issue_wen = 1'b1; issue_waddr = 5'd3;
    #1 chk1("post rst mem_ready", mem_ready, 1'b1);
    chk1("post rst wb_commit", wb_commit, 1'b0);
    chk1("post rst write_ready", write_ready, 1'b1);
    chk1("post rst issue_ready", issue_ready, 1'b1);
    step();

    // Randomized traffic with narrow addresses to force collisions.
    for (int n = 0; n < 600; n++) begin
      rst_n         = ($urandom_range(0, 99) != 0);
      issue_valid   = $urandom_range(0, 1) == 1;
      issue_wen     = $urandom_range(0, 3) != 0;
      issue_waddr   = 5'($urandom_range(0, 7));
      id_rs1        = 5'($urandom_range(0, 7));
      id_rs2        = 5'($urandom_range(0, 7));
      mem_valid     = $urandom_range(0, 1) == 1;
      mem_reg_wen   = $urandom_range(0, 3) != 0;
      mem_reg_waddr = 5'($urandom_range(0, 7));
      mem_alu_res   = {$urandom, $urandom};
      mem_rdata     = {$urandom, $urandom};
      mem_load      = $urandom_range(0, 1) == 1;
      mem_ld_size   = 2'($urandom_range(0, 3));
      mem_ld_signed = $urandom_range(0, 1) == 1;
      wb_stall      = $urandom_range(0, 3) == 0;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
